trace_dump_ctrl: RTL and testbench
==================================

# trace_dump_ctrl

Control and readout engine for the 1024 x 32-bit trace RAM. It arms, stops and clears capture, forwards trace words from the local event source, and tracks how many words were stored. On command it drains the stored words oldest-first onto a 32-bit valid/ready stream toward the register/DMA side. It is the reader end of the trace RAM port (trace_clr/enb/we/wd/re/mode in, trace_rd out).

## Interface
- TRACE_DEPTH, 1024: trace RAM words; the pointer is 10 bits and wraps at this depth.
- FIFO_DEPTH, 4: output buffer depth; also the read-credit limit.
- user_clk  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- cmd_start  in  1  pulse: clear RAM pointer, begin capture
- cmd_stop  in  1  pulse: end capture
- cmd_dump  in  1  pulse: drain stored words
- cfg_mode  in  1  0 = wrap (keep newest), 1 = stop when full; latched at cmd_start
- cap_we / cap_wd  in  1 / 32  trace source write strobe / data
- trace_clr, trace_enb, trace_we, trace_re, trace_mode  out  1  trace RAM controls
- trace_wd  out  32  trace RAM write data
- trace_rd  in  32  trace RAM read data; valid exactly 2 cycles after trace_re, zero otherwise
- m_valid, m_last  out  1;  m_data  out  32;  m_ready  in  1  output stream
- busy  out  1  state != IDLE
- word_cnt  out  11  stored words, saturating at 1024
- overflow  out  1  wrap occurred (mode 0) or a write was dropped (mode 1)
- dump_done  out  1  one-cycle pulse when drain completes

## Operation
- States: IDLE, ARM, CAPTURE, PREP, DRAIN.
- IDLE, cmd_start: latch cfg_mode, clear word_cnt and overflow, go to ARM. cmd_start beats cmd_dump in the same cycle. Commands are ignored in all other states, except cmd_stop in CAPTURE.
- ARM: trace_clr=1 for one cycle with trace_enb=0, then go to CAPTURE.
- CAPTURE: trace_enb=1, trace_we=cap_we, trace_wd=cap_wd (combinational pass-through).
  - Accepted write: cap_we & ~inh. Here inh = mode 1 & word_cnt==1024, which mirrors the RAM-side inhibit.
  - Accepted write: word_cnt increments, saturating at 1024.
  - Mode 0 write at word_cnt==1024: set overflow.
  - Mode 1 write while inh: set overflow; the write is dropped.
  - cmd_stop goes to IDLE. A write in the same cycle is still accepted.
- IDLE, cmd_dump:
  - word_cnt==0: pulse dump_done and stay in IDLE.
  - Otherwise go to PREP.
- PREP: sets the start address, since the RAM read pointer equals its write pointer.
  - Mode 0 with word_cnt==1024: no clear; reading starts at the current pointer, which holds the oldest word.
  - All other cases: trace_clr=1 for one cycle so reading starts at address 0.
  - Then go to DRAIN with remaining=word_cnt.
- DRAIN:
  - Issue trace_re=1 while remaining>0 and (in-flight + FIFO occupancy) < FIFO_DEPTH. Each issue decrements remaining.
  - A 2-stage shift register of issue flags captures trace_rd into the FIFO 2 cycles after each issue.
  - m_last accompanies the word-count-th word.
  - When the last beat is accepted (m_valid & m_ready & m_last): pulse dump_done and go to IDLE.
- trace_mode = latched cfg_mode at all times.

## Timing
- Reset values: state IDLE; all outputs 0; word_cnt 0; FIFO empty; latched mode 0.
- Reset mid-operation aborts immediately. Any stream beat in progress is discarded.
- cmd_start to first enabled write: 2 cycles (ARM, then CAPTURE).
- cmd_dump to first trace_re: 2 cycles (PREP, then DRAIN). First m_valid appears 2 cycles after the first trace_re.
- Drain throughput: 1 word/cycle when m_ready stays high.
- The credit rule guarantees the FIFO never overflows under any m_ready pattern.
- m_data and m_last hold stable while m_valid & ~m_ready.
- FIFO simultaneous push and pop when full: pop first (credit accounting makes push-to-full-without-pop impossible).

## Structure
- Package trace_pkg holds: state enum (3 bits), TRACE_DEPTH, TRACE_AW=10, TRACE_DW=32.
- Sub-module trace_dump_fifo holds the FIFO_DEPTH x 33 buffer (data + last) with a count output.
- The controller FSM, counters and credit logic live in the top module. Target size is about 250 lines.

## Test plan
- Mode 0, 5 writes (0x100..0x104), stop, dump with m_ready=1 -> 5 beats 0x100..0x104, last on 0x104, word_cnt=5, overflow=0.
- Mode 0, 1030 writes of values 0..1029, dump -> 1024 beats 6..1029, overflow=1, no trace_clr during PREP.
- Mode 1, 1030 writes -> beats 0..1023, overflow=1, trace_we suppressed from write 1025 onward.
- Dump of 8 words with m_ready toggling at random and held low for 10 cycles -> no loss or duplication, data stable while stalled, at most 4 reads in flight.
- cmd_dump with word_cnt=0 -> dump_done 1 cycle later, no trace_re, m_valid stays 0.
- Reset asserted mid-DRAIN -> outputs 0 next cycle; a fresh start and dump of 3 words then completes correctly.

Source files
------------

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared constants and state encoding for the trace dump controller
package trace_pkg;

    localparam int TRACE_DEPTH = 1024;
    localparam int TRACE_AW    = 10;
    localparam int TRACE_DW    = 32;
    localparam int FIFO_DEPTH  = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_PREP    = 3'd3,
        ST_DRAIN   = 3'd4
    } trace_state_e;

endpackage

// File: rtl/trace_dump_ctrl_if.sv
// rtl/trace_dump_ctrl_if.sv - valid/ready readout stream toward the register/DMA side
interface trace_dump_ctrl_if;
    import trace_pkg::*;

    logic                m_valid;
    logic [TRACE_DW-1:0] m_data;
    logic                m_last;
    logic                m_ready;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);

endinterface

// File: rtl/trace_dump_fifo.sv
// rtl/trace_dump_fifo.sv - small first-word-fall-through output buffer with bypass when empty
module trace_dump_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic                         user_clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             empty;
    logic             bypass;
    logic             wr_en;
    logic             rd_en;

    // An empty buffer presents the incoming word directly; it is only stored
    // if the consumer does not take it in the same cycle.
    assign empty     = (count == '0);
    assign bypass    = empty & push & out_ready;
    assign wr_en     = push & ~bypass;
    assign rd_en     = ~empty & out_ready;
    assign out_valid = ~empty | push;
    assign out_data  = empty ? push_data : mem[rd_ptr];

    // Storage array, no reset needed since empty slots are never presented
    always_ff @(posedge user_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; a pop and push when full both proceed
    always_ff @(posedge user_clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + PW'(1);
            end
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

endmodule

// File: rtl/trace_dump_ctrl.sv
// rtl/trace_dump_ctrl.sv - trace RAM capture control and oldest-first drain engine
module trace_dump_ctrl
    import trace_pkg::*;
(
    input  logic                user_clk,
    input  logic                reset,
    input  logic                cmd_start,
    input  logic                cmd_stop,
    input  logic                cmd_dump,
    input  logic                cfg_mode,
    input  logic                cap_we,
    input  logic [TRACE_DW-1:0] cap_wd,
    output logic                trace_clr,
    output logic                trace_enb,
    output logic                trace_we,
    output logic [TRACE_DW-1:0] trace_wd,
    output logic                trace_re,
    output logic                trace_mode,
    input  logic [TRACE_DW-1:0] trace_rd,
    output logic                busy,
    output logic [TRACE_AW:0]   word_cnt,
    output logic                overflow,
    output logic                dump_done,
    trace_dump_ctrl_if.master   m_if
);
    localparam int              FCW      = $clog2(FIFO_DEPTH+1);
    localparam logic [TRACE_AW:0] FULL_CNT = (TRACE_AW+1)'(TRACE_DEPTH);
    localparam logic [TRACE_AW:0] ONE_CNT  = (TRACE_AW+1)'(1);

    trace_state_e        state;
    logic                mode_q;
    logic [TRACE_AW:0]   remaining;
    logic [TRACE_AW:0]   push_idx;
    logic [1:0]          issue_q;
    logic [FCW-1:0]      fifo_count;
    logic [FCW:0]        outstanding;
    logic                full;
    logic                inh;
    logic                wr_hit;
    logic                prep_clr;
    logic                push;
    logic [TRACE_DW:0]   push_data;
    logic [TRACE_DW:0]   fifo_out;
    logic                fifo_valid;
    logic                pop_last;

    assign full   = (word_cnt == FULL_CNT);
    // Matches the RAM's own write inhibit in stop-when-full mode
    assign inh    = mode_q & full;
    assign wr_hit = (state == ST_CAPTURE) & cap_we;
    // A full wrap-mode buffer already has its pointer on the oldest word
    assign prep_clr = ~(~mode_q & full);

    assign trace_clr  = (state == ST_ARM) | ((state == ST_PREP) & prep_clr);
    assign trace_enb  = (state == ST_CAPTURE);
    assign trace_we   = wr_hit & ~inh;
    assign trace_wd   = (state == ST_CAPTURE) ? cap_wd : '0;
    assign trace_mode = mode_q;
    assign busy       = (state != ST_IDLE);

    // Reads in the RAM pipeline plus buffered words may never exceed the buffer size
    assign outstanding = (FCW+1)'(issue_q[0]) + (FCW+1)'(issue_q[1]) + (FCW+1)'(fifo_count);
    assign trace_re    = (state == ST_DRAIN) & (remaining != '0) &
                         (outstanding < (FCW+1)'(FIFO_DEPTH));

    assign push      = issue_q[1];
    assign push_data = push ? {(push_idx == word_cnt - ONE_CNT), trace_rd} : '0;

    trace_dump_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (TRACE_DW+1)
    ) u_fifo (
        .user_clk  (user_clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .out_valid (fifo_valid),
        .out_data  (fifo_out),
        .out_ready (m_if.m_ready),
        .count     (fifo_count)
    );

    assign m_if.m_valid = fifo_valid;
    assign m_if.m_data  = fifo_out[TRACE_DW-1:0];
    assign m_if.m_last  = fifo_out[TRACE_DW];
    assign pop_last     = fifo_valid & m_if.m_ready & fifo_out[TRACE_DW];

    // Command FSM, capture counters and drain bookkeeping
    always_ff @(posedge user_clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            mode_q    <= 1'b0;
            word_cnt  <= '0;
            overflow  <= 1'b0;
            remaining <= '0;
            push_idx  <= '0;
            issue_q   <= '0;
            dump_done <= 1'b0;
        end else begin
            dump_done <= 1'b0;
            issue_q   <= {issue_q[0], trace_re};
            if (push) begin
                push_idx <= push_idx + ONE_CNT;
            end
            case (state)
                ST_IDLE: begin
                    if (cmd_start) begin
                        mode_q   <= cfg_mode;
                        word_cnt <= '0;
                        overflow <= 1'b0;
                        state    <= ST_ARM;
                    end else if (cmd_dump) begin
                        if (word_cnt == '0) begin
                            dump_done <= 1'b1;
                        end else begin
                            state <= ST_PREP;
                        end
                    end
                end
                ST_ARM: begin
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (wr_hit & ~full) begin
                        word_cnt <= word_cnt + ONE_CNT;
                    end
                    if (wr_hit & full) begin
                        overflow <= 1'b1;
                    end
                    if (cmd_stop) begin
                        state <= ST_IDLE;
                    end
                end
                ST_PREP: begin
                    remaining <= word_cnt;
                    push_idx  <= '0;
                    state     <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (trace_re) begin
                        remaining <= remaining - ONE_CNT;
                    end
                    if (pop_last) begin
                        dump_done <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trace_dump_ctrl.sv
// tb/tb_trace_dump_ctrl.sv - self-checking bench for trace_dump_ctrl with a trace RAM model
module tb_trace_dump_ctrl;
    import trace_pkg::*;

    logic        user_clk = 1'b0;
    logic        reset    = 1'b1;
    logic        cmd_start = 1'b0, cmd_stop = 1'b0, cmd_dump = 1'b0, cfg_mode = 1'b0;
    logic        cap_we = 1'b0;
    logic [31:0] cap_wd = '0;
    logic        trace_clr, trace_enb, trace_we, trace_re, trace_mode;
    logic [31:0] trace_wd, trace_rd;
    logic        busy, overflow, dump_done;
    logic [10:0] word_cnt;

    trace_dump_ctrl_if m_if ();

    always #5 user_clk = ~user_clk;

    trace_dump_ctrl dut (
        .user_clk   (user_clk),
        .reset      (reset),
        .cmd_start  (cmd_start),
        .cmd_stop   (cmd_stop),
        .cmd_dump   (cmd_dump),
        .cfg_mode   (cfg_mode),
        .cap_we     (cap_we),
        .cap_wd     (cap_wd),
        .trace_clr  (trace_clr),
        .trace_enb  (trace_enb),
        .trace_we   (trace_we),
        .trace_wd   (trace_wd),
        .trace_re   (trace_re),
        .trace_mode (trace_mode),
        .trace_rd   (trace_rd),
        .busy       (busy),
        .word_cnt   (word_cnt),
        .overflow   (overflow),
        .dump_done  (dump_done),
        .m_if       (m_if)
    );

    // Trace RAM model: shared read/write pointer, read data two cycles after trace_re
    logic [31:0] mem [1024];
    logic [9:0]  ram_ptr = '0;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [31:0] d0 = '0, d1 = '0;
    always @(posedge user_clk) begin
        v0 <= trace_re;
        d0 <= trace_re ? mem[ram_ptr] : 32'h0;
        v1 <= v0;
        d1 <= d0;
        if (trace_clr) ram_ptr <= '0;
        else if (trace_enb && trace_we) begin
            mem[ram_ptr] <= trace_wd;
            ram_ptr <= ram_ptr + 10'd1;
        end else if (trace_re) ram_ptr <= ram_ptr + 10'd1;
    end
    assign trace_rd = v1 ? d1 : 32'h0;

    int tests = 0, fails = 0, cyc_n = 0;
    int re_cnt, clr_cnt, we_cnt, done_cnt, acc_cnt, stab_err, out_max, v_cnt, busy_cnt;
    int first_re, first_v, last_acc, first_done;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [31:0] beat_q [$];
    logic        last_q [$];

    typedef struct {
        logic        mode;
        int          nwr;
        logic [31:0] base;
        int          exp_cnt;
        logic        exp_ovf;
        int          exp_we;
        logic [31:0] exp_first;
        int          exp_clr;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic mon_clear();
        re_cnt = 0; clr_cnt = 0; we_cnt = 0; done_cnt = 0; acc_cnt = 0; stab_err = 0;
        out_max = 0; v_cnt = 0; busy_cnt = 0;
        first_re = -1; first_v = -1; last_acc = -1; first_done = -1;
        prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        beat_q.delete(); last_q.delete();
    endtask

    // One clock: sample outputs at the falling edge, then return just after the rising edge
    task automatic cyc();
        @(negedge user_clk);
        if (trace_re) begin re_cnt++; if (first_re < 0) first_re = cyc_n; end
        if (trace_clr) clr_cnt++;
        if (trace_we) we_cnt++;
        if (busy) busy_cnt++;
        if (dump_done) begin done_cnt++; if (first_done < 0) first_done = cyc_n; end
        if (prev_stall && (!m_if.m_valid || m_if.m_data !== prev_data || m_if.m_last !== prev_last))
            stab_err++;
        if (m_if.m_valid) begin v_cnt++; if (first_v < 0) first_v = cyc_n; end
        if (m_if.m_valid && m_if.m_ready) begin
            beat_q.push_back(m_if.m_data);
            last_q.push_back(m_if.m_last);
            acc_cnt++;
            last_acc = cyc_n;
        end
        if (re_cnt - acc_cnt > out_max) out_max = re_cnt - acc_cnt;
        prev_stall = m_if.m_valid && !m_if.m_ready;
        prev_data  = m_if.m_data;
        prev_last  = m_if.m_last;
        cyc_n++;
        @(posedge user_clk);
        #1;
    endtask

    task automatic do_capture(input logic mode, input int n, input logic [31:0] base);
        cfg_mode = mode; cmd_start = 1'b1; cyc();
        cmd_start = 1'b0; cfg_mode = 1'b0; cyc();
        for (int i = 0; i < n; i++) begin
            cap_we = 1'b1; cap_wd = base + 32'(i); cyc();
        end
        cap_we = 1'b0; cap_wd = '0; cmd_stop = 1'b1; cyc();
        cmd_stop = 1'b0; cyc();
    endtask

    // rmode 0: m_ready always high; rmode 1: random with a 10-cycle low window
    task automatic do_dump(input int rmode, output int c0);
        mon_clear();
        c0 = cyc_n;
        cmd_dump = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if (rmode == 0) m_if.m_ready = 1'b1;
            else if (k >= 4 && k < 14) m_if.m_ready = 1'b0;
            else m_if.m_ready = 1'($urandom_range(0, 1));
            cyc();
            cmd_dump = 1'b0;
            if (done_cnt > 0) break;
        end
        m_if.m_ready = 1'b1;
    endtask

    task automatic check_beats(input string tag, input int n, input logic [31:0] first);
        int derr = 0, lerr = 0;
        for (int j = 0; j < beat_q.size(); j++) begin
            if (beat_q[j] !== first + 32'(j)) derr++;
            if (last_q[j] !== (j == n - 1)) lerr++;
        end
        chk({tag, " beats"}, acc_cnt, n);
        chk({tag, " data errors"}, derr, 0);
        chk({tag, " last errors"}, lerr, 0);
        chk({tag, " dump_done"}, done_cnt, 1);
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, " m_valid"}, m_if.m_valid, 0);
        chk({tag, " m_data/m_last"}, {m_if.m_last, m_if.m_data}, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " word_cnt"}, word_cnt, 0);
        chk({tag, " ctl outs"}, {trace_clr, trace_enb, trace_we, trace_re, trace_mode, overflow, dump_done}, 0);
        chk({tag, " trace_wd"}, trace_wd, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        vecs[0] = '{1'b0,    5, 32'h100,  5,    1'b0,    5, 32'h100,  1};
        vecs[1] = '{1'b0, 1030, 32'h0,    1024, 1'b1, 1030, 32'h6,    0};
        vecs[2] = '{1'b1, 1030, 32'h0,    1024, 1'b1, 1024, 32'h0,    1};
        vecs[3] = '{1'b1,    1, 32'hABC,  1,    1'b0,    1, 32'hABC,  1};
        vecs[4] = '{1'b0, 1024, 32'h5000, 1024, 1'b0, 1024, 32'h5000, 0};
        vecs[5] = '{1'b1, 1024, 32'h7000, 1024, 1'b0, 1024, 32'h7000, 1};

        m_if.m_ready = 1'b1;
        mon_clear();
        cyc();
        chk_zero_outs("reset");
        reset = 1'b0;
        cyc();

        // Empty dump: immediate dump_done, no reads, no beats
        mon_clear();
        c0 = cyc_n;
        cmd_dump = 1'b1; cyc();
        cmd_dump = 1'b0;
        for (int k = 0; k < 5; k++) cyc();
        chk("empty dump_done count", done_cnt, 1);
        chk("empty dump_done latency", first_done - c0, 1);
        chk("empty trace_re", re_cnt, 0);
        chk("empty m_valid", v_cnt, 0);
        chk("empty busy", busy_cnt, 0);

        foreach (vecs[v]) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            mon_clear();
            do_capture(vecs[v].mode, vecs[v].nwr, vecs[v].base);
            chk({tag, " word_cnt"}, word_cnt, vecs[v].exp_cnt);
            chk({tag, " overflow"}, overflow, vecs[v].exp_ovf);
            chk({tag, " trace_mode"}, trace_mode, vecs[v].mode);
            chk({tag, " trace_we count"}, we_cnt, vecs[v].exp_we);
            do_dump(0, c0);
            check_beats(tag, vecs[v].exp_cnt, vecs[v].exp_first);
            chk({tag, " prep trace_clr"}, clr_cnt, vecs[v].exp_clr);
            chk({tag, " dump to re"}, first_re - c0, 2);
            chk({tag, " re to valid"}, first_v - first_re, 2);
            chk({tag, " throughput"}, last_acc - first_v, vecs[v].exp_cnt - 1);
            chk({tag, " reads issued"}, re_cnt, vecs[v].exp_cnt);
            chk({tag, " busy after"}, busy, 0);
        end

        // cmd_start wins over cmd_dump; ARM then CAPTURE
        cfg_mode = 1'b0; cmd_start = 1'b1; cmd_dump = 1'b1;
        cyc();
        cmd_start = 1'b0; cmd_dump = 1'b0;
        chk("start+dump ARM clr/enb/re", {trace_clr, trace_enb, trace_re}, 3'b100);
        chk("start+dump word_cnt", word_cnt, 0);
        chk("start+dump overflow", overflow, 0);
        chk("start+dump mode", trace_mode, 0);
        cyc();
        chk("start CAPTURE clr/enb", {trace_clr, trace_enb}, 2'b01);
        cmd_stop = 1'b1; cyc();
        cmd_stop = 1'b0; cyc();
        chk("stop busy", busy, 0);

        // Stalled dump of 8 words with random backpressure
        mon_clear();
        do_capture(1'b0, 8, 32'hA0);
        do_dump(1, c0);
        check_beats("stall", 8, 32'hA0);
        chk("stall data stability", stab_err, 0);
        chk("stall max in flight", out_max, 4);

        // Reset while draining aborts at once, then a fresh run completes
        mon_clear();
        do_capture(1'b1, 20, 32'h300);
        m_if.m_ready = 1'b0;
        cmd_dump = 1'b1; cyc();
        cmd_dump = 1'b0;
        for (int k = 0; k < 6; k++) cyc();
        chk("pre-reset m_valid", m_if.m_valid, 1);
        reset = 1'b1;
        @(negedge user_clk);
        chk_zero_outs("midreset");
        @(posedge user_clk); #1;
        reset = 1'b0;
        m_if.m_ready = 1'b1;
        cyc();
        mon_clear();
        do_capture(1'b0, 3, 32'hBEEF0);
        chk("post-reset word_cnt", word_cnt, 3);
        do_dump(0, c0);
        check_beats("post-reset", 3, 32'hBEEF0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
